req_arbiter_8: RTL
==================

// Module: req_arbiter_8
// PURPOSE
//  8-requester arbiter that shares one resource slot, using priority-encoder style winner selection.
//  Samples the req vector each clock and issues a registered one-hot grant plus its 3-bit index.
//  Holds the grant until the owner drops req, or until a hold limit expires and another requester waits.
//  Selectable fixed priority (bit 7 highest, as the 8:3 encoder) or round-robin fairness.
// PARAMETERS
//  RR_EN     1   1 = round-robin starting after last owner; 0 = fixed priority, index 7 highest
//  MAX_HOLD  16  max consecutive grant cycles while others wait; 0 = unlimited (no preemption)
//  HOLD_W    $clog2(MAX_HOLD+1)  hold counter width (derived, not overridden)
// PORTS
//  clk        in   1  clock; all state updates on posedge
//  rst        in   1  asynchronous, active-high reset
//  EN         in   1  arbitration enable; low blocks new grants, does not revoke current grant
//  req        in   8  request vector; req[i] held high for as long as requester i wants the slot
//  gnt        out  8  one-hot grant, registered; 8'h00 when idle
//  gnt_idx    out  3  binary index of gnt bit; 0 when idle
//  gnt_valid  out  1  high while any grant is active
//  preempt    out  1  one-cycle pulse in the cycle the new grant follows a forced release
// BEHAVIOUR
//  Reset (async, immediate): gnt=0, gnt_idx=0, gnt_valid=0, preempt=0, state=IDLE, hold_cnt=0, last=3'd7.
//  FSM: IDLE, BUSY.
//  IDLE: if EN && |req at posedge -> winner registered; gnt/gnt_idx/gnt_valid valid after that edge (1-cycle latency); ->BUSY.
//  Winner select: RR_EN=0 -> highest set index. RR_EN=1 -> first set bit scanning last+1, last+2, ... wrap mod 8.
//  BUSY, normal release: req[gnt_idx]==0 at posedge -> last<=gnt_idx; if EN && other req set, grant the new
//    winner on the same edge (back-to-back, no bubble, stay BUSY); else gnt=0, gnt_valid=0, ->IDLE.
//  hold_cnt: cleared on each new grant; +1 per BUSY cycle; saturates at MAX_HOLD.
//  Forced release: MAX_HOLD!=0 && hold_cnt==MAX_HOLD-1 && req[gnt_idx] && EN && (req & ~gnt)!=0
//    -> winner chosen from req & ~gnt; last<=old gnt_idx; preempt=1 for exactly the first cycle of the new grant.
//  No other requester pending at limit: owner keeps grant, hold_cnt saturates, no preempt.
//  EN low in BUSY: owner keeps grant; no preemption; on release -> IDLE.
//  Simultaneous release and new req in the same cycle: both are seen at the same edge; the new req competes normally.
//  Release and limit in the same cycle: treated as a normal release; preempt stays 0.
//  req bits that drop before they are granted are simply lost; the block does no queuing.
//  Invariants: gnt is one-hot or zero; gnt_valid == |gnt; gnt == 8'b1 << gnt_idx when valid.
//  rst asserted mid-grant: outputs clear asynchronously; the first post-reset arbitration scans from index 0 (RR).
// STRUCTURE
//  Package arb_pkg: localparam N_REQ=8, IDX_W=3; typedef enum logic {IDLE, BUSY} arb_state_t;
//    typedef logic [N_REQ-1:0] req_vec_t.
//  Sub-module arb_pick (combinational): inputs req_vec_t req, mask, last, rr_en; outputs idx, found.
//    Rotates req by last+1 for RR, then priority-encodes.
//  Top level: FSM, hold counter, last pointer, output registers. One always_ff for state, one always_comb
//    for next state; single clk, async rst.
// TESTING
//  1 RR_EN=0, req=8'h81 -> next edge gnt=8'h80, gnt_idx=7, gnt_valid=1; drop req[7] -> gnt=8'h01 next edge, idx=0.
//  2 RR_EN=1 after reset, req=8'h05 -> gnt_idx=0; drop bit0 -> gnt_idx=2 on the very next edge (no idle cycle).
//  3 MAX_HOLD=4, req=8'h03 held -> idx 0 for 4 cycles, preempt pulse, idx 1 for 4 cycles, alternating forever.
//  4 MAX_HOLD=4, req=8'h10 alone held 10 cycles -> gnt=8'h10 throughout, preempt never asserts.
//  5 EN=0, req=8'h20 -> gnt stays 0; raise EN -> gnt=8'h20 one edge later; lower EN while held -> grant kept.
//  6 rst pulse mid-grant (async, between edges) -> gnt, gnt_valid, gnt_idx = 0 immediately;
//    after release with req=8'hFF -> idx 0 granted first.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and sizes for the 8-requester arbiter slice.
package arb_pkg;
    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic {IDLE, BUSY} arb_state_t;
    typedef logic [N_REQ-1:0] req_vec_t;
    typedef logic [IDX_W-1:0] idx_t;
endpackage

// File: rtl/arb_pick.sv
// Combinational winner picker: fixed priority (highest index wins) or
// round-robin scan starting just after the last owner.
import arb_pkg::*;

module arb_pick (
    input  req_vec_t req,
    input  req_vec_t mask,
    input  idx_t     last,
    input  logic     rr_en,
    output idx_t     idx,
    output logic     found
);

    req_vec_t eligible;
    idx_t     start;
    idx_t     cand;

    // Scanning downwards lets the candidate closest to the start overwrite the rest.
    always_comb begin
        eligible = req & mask;
        found    = |eligible;
        start    = last + idx_t'(1);
        cand     = '0;
        idx      = '0;
        if (rr_en) begin
            for (int k = N_REQ - 1; k >= 0; k--) begin
                cand = start + idx_t'(k);
                if (eligible[cand]) begin
                    idx = cand;
                end
            end
        end else begin
            for (int k = 0; k < N_REQ; k++) begin
                if (eligible[k]) begin
                    idx = idx_t'(k);
                end
            end
        end
    end

endmodule

// File: rtl/req_arbiter_8.sv
// 8-requester single-slot arbiter with registered one-hot grant, optional
// round-robin fairness and a hold limit that preempts an owner while others wait.
import arb_pkg::*;

module req_arbiter_8 #(
    parameter bit RR_EN    = 1'b1,
    parameter int MAX_HOLD = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 EN,
    input  logic [N_REQ-1:0]     req,
    output logic [N_REQ-1:0]     gnt,
    output logic [IDX_W-1:0]     gnt_idx,
    output logic                 gnt_valid,
    output logic                 preempt
);

    localparam int HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_SAT = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LIM = (MAX_HOLD > 0) ? HOLD_W'(MAX_HOLD - 1) : '0;

    arb_state_t          state, nxt_state;
    logic [HOLD_W-1:0]   hold_cnt, nxt_hold;
    idx_t                last, nxt_last;
    idx_t                nxt_idx;
    logic                nxt_valid;
    logic                nxt_preempt;
    req_vec_t            nxt_gnt;

    req_vec_t            pick_mask;
    idx_t                pick_last;
    idx_t                pick_idx;
    logic                pick_found;

    // While busy the owner is excluded and the scan starts after it, which serves
    // both a normal hand-over and a forced release.
    assign pick_mask = (state == BUSY) ? ~gnt : '1;
    assign pick_last = (state == BUSY) ? gnt_idx : last;

    arb_pick u_pick (
        .req   (req),
        .mask  (pick_mask),
        .last  (pick_last),
        .rr_en (RR_EN),
        .idx   (pick_idx),
        .found (pick_found)
    );

    always_comb begin
        nxt_state   = state;
        nxt_hold    = hold_cnt;
        nxt_last    = last;
        nxt_idx     = gnt_idx;
        nxt_valid   = gnt_valid;
        nxt_preempt = 1'b0;
        case (state)
            IDLE: begin
                if (EN && pick_found) begin
                    nxt_idx   = pick_idx;
                    nxt_valid = 1'b1;
                    nxt_hold  = '0;
                    nxt_state = BUSY;
                end
            end
            BUSY: begin
                if (!req[gnt_idx]) begin
                    nxt_last = gnt_idx;
                    if (EN && pick_found) begin
                        nxt_idx  = pick_idx;
                        nxt_hold = '0;
                    end else begin
                        nxt_idx   = '0;
                        nxt_valid = 1'b0;
                        nxt_state = IDLE;
                    end
                end else if (MAX_HOLD != 0 && hold_cnt == HOLD_LIM && EN && pick_found) begin
                    nxt_last    = gnt_idx;
                    nxt_idx     = pick_idx;
                    nxt_hold    = '0;
                    nxt_preempt = 1'b1;
                end else if (hold_cnt != HOLD_SAT) begin
                    nxt_hold = hold_cnt + HOLD_W'(1);
                end
            end
            default: nxt_state = IDLE;
        endcase
        nxt_gnt = nxt_valid ? (req_vec_t'(1) << nxt_idx) : '0;
    end

    // last resets to 7 so the first round-robin scan after reset begins at index 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            hold_cnt  <= '0;
            last      <= idx_t'(N_REQ - 1);
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            preempt   <= 1'b0;
        end else begin
            state     <= nxt_state;
            hold_cnt  <= nxt_hold;
            last      <= nxt_last;
            gnt       <= nxt_gnt;
            gnt_idx   <= nxt_idx;
            gnt_valid <= nxt_valid;
            preempt   <= nxt_preempt;
        end
    end

endmodule
